// File: rtl/fetch_arb_pkg.sv
// Shared types and defaults for the two-requester RAM read-port arbiter.
package fetch_arb_pkg;

  localparam int A_S_DEF = 8;
  localparam int D_S_DEF = 32;

  typedef logic       req_id_t;
  typedef logic [1:0] gnt_t;

  // Round-robin pick: on contention, favour the requester not served last.
  function automatic gnt_t rr_pick(input logic [1:0] elig, input req_id_t last_gnt);
    if (elig == 2'b11) begin
      return last_gnt ? gnt_t'(2'b01) : gnt_t'(2'b10);
    end
    return gnt_t'(elig);
  endfunction

endpackage

// File: rtl/retension_ff.sv
// Single-entry output stage: the return word passes straight through in its
// return cycle and is held afterwards until the consumer takes it.
module retension_ff #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy
);

  logic             hold_vld_reg;
  logic             hold_vld_next;
  logic [WIDTH-1:0] data_reg;

  always_comb begin
    dout_vld      = din_vld | hold_vld_reg;
    dout          = din_vld ? din : data_reg;
    hold_vld_next = dout_vld & ~dout_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_reg <= 1'b0;
    end else begin
      hold_vld_reg <= hold_vld_next;
    end
    // Payload is kept across reset; only the valid flag matters.
    if (din_vld) begin
      data_reg <= din;
    end
  end

endmodule

// File: rtl/fetch_arb_2.sv
// Round-robin sharing of one synchronous-read RAM port between two fetch
// requesters, with a per-requester output stage that holds under back-pressure.
module fetch_arb_2
  import fetch_arb_pkg::*;
#(
  parameter int A_S = A_S_DEF,
  parameter int D_S = D_S_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_vld,
  input  logic [A_S-1:0] r0_addr,
  output logic           r0_rdy,
  input  logic           r1_vld,
  input  logic [A_S-1:0] r1_addr,
  output logic           r1_rdy,
  output logic           ram_reb,
  output logic [A_S-1:0] ram_addrb,
  input  logic [D_S-1:0] ram_doutb,
  output logic           d0_vld,
  output logic [D_S-1:0] d0_pl,
  input  logic           d0_rdy,
  output logic           d1_vld,
  output logic [D_S-1:0] d1_pl,
  input  logic           d1_rdy
);

  logic [1:0]     r_vld;
  logic [1:0]     d_rdy;
  logic [1:0]     d_vld;
  logic [1:0]     elig;
  logic [1:0]     rtn_hit;
  logic [D_S-1:0] d_pl [2];
  gnt_t           gnt;

  req_id_t last_gnt_reg;
  req_id_t last_gnt_next;
  logic    rtn_vld_reg;
  logic    rtn_vld_next;
  req_id_t rtn_id_reg;
  req_id_t rtn_id_next;

  assign r_vld = {r1_vld, r0_vld};
  assign d_rdy = {d1_rdy, d0_rdy};

  // Eligibility depends only on registered state and consumer readiness,
  // never on ram_doutb.
  always_comb begin
    elig          = 2'b00;
    gnt           = gnt_t'(2'b00);
    ram_addrb     = '0;
    last_gnt_next = last_gnt_reg;
    rtn_vld_next  = 1'b0;
    rtn_id_next   = rtn_id_reg;

    if (!rst) begin
      elig = r_vld & (~d_vld | d_rdy);
    end
    gnt = rr_pick(elig, last_gnt_reg);

    if (gnt[0]) begin
      ram_addrb = r0_addr;
    end else if (gnt[1]) begin
      ram_addrb = r1_addr;
    end

    if (|gnt) begin
      last_gnt_next = req_id_t'(gnt[1]);
      rtn_vld_next  = 1'b1;
      rtn_id_next   = req_id_t'(gnt[1]);
    end
  end

  assign r0_rdy  = gnt[0];
  assign r1_rdy  = gnt[1];
  assign ram_reb = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_reg <= req_id_t'(1'b1);
      rtn_vld_reg  <= 1'b0;
      rtn_id_reg   <= req_id_t'(1'b0);
    end else begin
      last_gnt_reg <= last_gnt_next;
      rtn_vld_reg  <= rtn_vld_next;
      rtn_id_reg   <= rtn_id_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      // A return landing in a reset cycle is dropped.
      assign rtn_hit[gi] = rtn_vld_reg & ~rst & (rtn_id_reg == req_id_t'(gi));

      retension_ff #(
        .WIDTH(D_S)
      ) u_ret (
        .clk      (clk),
        .rst      (rst),
        .din      (ram_doutb),
        .din_vld  (rtn_hit[gi]),
        .dout     (d_pl[gi]),
        .dout_vld (d_vld[gi]),
        .dout_rdy (d_rdy[gi])
      );
    end
  endgenerate

  assign d0_vld = d_vld[0];
  assign d1_vld = d_vld[1];
  assign d0_pl  = d_pl[0];
  assign d1_pl  = d_pl[1];

endmodule

// File: tb/tb_fetch_arb_2.sv
// Directed bench for fetch_arb_2: per-cycle grant checks plus a per-port
// scoreboard of expected return words checked by an independent monitor.
module tb_fetch_arb_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_vld, r1_vld;
  logic [7:0]  r0_addr, r1_addr;
  logic        r0_rdy, r1_rdy;
  logic        ram_reb;
  logic [7:0]  ram_addrb;
  logic [31:0] ram_doutb;
  logic        d0_vld, d1_vld;
  logic [31:0] d0_pl, d1_pl;
  logic        d0_rdy, d1_rdy;

  int checks = 0;
  int passes = 0;
  int cyc_n  = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  fetch_arb_2 #(.A_S(8), .D_S(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_vld    (r0_vld),
    .r0_addr   (r0_addr),
    .r0_rdy    (r0_rdy),
    .r1_vld    (r1_vld),
    .r1_addr   (r1_addr),
    .r1_rdy    (r1_rdy),
    .ram_reb   (ram_reb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb),
    .d0_vld    (d0_vld),
    .d0_pl     (d0_pl),
    .d0_rdy    (d0_rdy),
    .d1_vld    (d1_vld),
    .d1_pl     (d1_pl),
    .d1_rdy    (d1_rdy)
  );

  // RAM model: word at address a is 32'h4000_0000 | a, one-cycle latency.
  always @(posedge clk) begin
    if (ram_reb) ram_doutb <= 32'h4000_0000 | {24'h0, ram_addrb};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("cyc %0d %s ok act=%h", cyc_n, name, act);
    end else begin
      $display("FAIL cyc %0d %s act=%h exp=%h", cyc_n, name, act, exp);
    end
  endtask

  // Monitor: transfers pop the expected word; held data must match the head.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (d0_vld === 1'b1) begin
        if (q0.size() == 0) chk("d0_unexpected", d0_pl, 32'hxxxx_xxxx);
        else if (d0_rdy) chk("d0_pop", d0_pl, q0.pop_front());
        else chk("d0_hold", d0_pl, q0[0]);
      end
      if (d1_vld === 1'b1) begin
        if (q1.size() == 0) chk("d1_unexpected", d1_pl, 32'hxxxx_xxxx);
        else if (d1_rdy) chk("d1_pop", d1_pl, q1.pop_front());
        else chk("d1_hold", d1_pl, q1[0]);
      end
    end
  end

  // g: hand-computed grant for this cycle (0 none, 1 requester 0, 2 requester 1).
  task automatic cyc(input logic v0, input logic [7:0] a0, input logic v1, input logic [7:0] a1,
                     input logic k0, input logic k1, input int g);
    logic [31:0] exp_v;
    r0_vld = v0; r0_addr = a0; r1_vld = v1; r1_addr = a1; d0_rdy = k0; d1_rdy = k1;
    exp_v = {21'h0, (g == 1), (g == 2), (g != 0), (g == 1) ? a0 : (g == 2) ? a1 : 8'h00};
    @(negedge clk);
    chk("grant{r0,r1,reb,addr}", {21'h0, r0_rdy, r1_rdy, ram_reb, ram_addrb}, exp_v);
    if (g == 1) q0.push_back(32'h4000_0000 | {24'h0, a0});
    if (g == 2) q1.push_back(32'h4000_0000 | {24'h0, a1});
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic rst_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; r0_vld = 1'b1; r1_vld = 1'b1; r0_addr = 8'h77; r1_addr = 8'h78;
      d0_rdy = 1'b1; d1_rdy = 1'b1;
      @(negedge clk);
      if (i == n - 1)
        chk("reset{r0,r1,reb,d0v,d1v}", {27'h0, r0_rdy, r1_rdy, ram_reb, d0_vld, d1_vld}, 32'h0);
      @(posedge clk); #1;
      cyc_n++;
    end
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    rst = 1'b1; r0_vld = 0; r1_vld = 0; r0_addr = 0; r1_addr = 0; d0_rdy = 1; d1_rdy = 1;
    @(posedge clk); #1;
    rst_cyc(2);

    // Single requests, then contention with last_gnt back at 1.
    cyc(1, 8'h05, 0, 8'h00, 1, 1, 1);
    cyc(0, 8'h00, 1, 8'h20, 1, 1, 2);
    cyc(1, 8'h10, 1, 8'h20, 1, 1, 1);
    cyc(1, 8'h10, 1, 8'h20, 1, 1, 2);
    cyc(1, 8'h10, 1, 8'h20, 1, 1, 1);
    cyc(1, 8'h10, 1, 8'h20, 1, 1, 2);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);

    // Back-pressure on port 1 while requester 0 streams.
    cyc(0, 8'h00, 1, 8'h21, 1, 1, 2);
    for (int i = 0; i < 5; i++) cyc(1, 8'h30, 1, 8'h22, 1, 0, 1);
    cyc(1, 8'h31, 1, 8'h22, 1, 1, 2);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);

    // Drain coinciding with a new port-0 return.
    cyc(1, 8'h40, 0, 8'h00, 0, 1, 1);
    cyc(1, 8'h41, 0, 8'h00, 0, 1, 0);
    cyc(1, 8'h41, 0, 8'h00, 1, 1, 1);
    cyc(1, 8'h42, 0, 8'h00, 1, 1, 1);
    cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);

    // Reset with a port-1 read in flight; next contention goes to requester 0.
    cyc(0, 8'h00, 1, 8'h55, 1, 1, 2);
    rst_cyc(1);
    cyc(1, 8'h60, 1, 8'h61, 1, 1, 1);

    // Idle.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);
      chk("idle{d0v,d1v}", {30'h0, d0_vld, d1_vld}, 32'h0);
    end
    chk("q0_left", q0.size(), 32'd0);
    chk("q1_left", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
